ps2_keycode_rx: RTL and testbench

// - PS/2 keyboard receiver that produces the 16-bit, two-slot HID-usage keycode bus.
//   The snake motion controller and other game logic consume this bus.
// - Deserialises scan-code-set-2 frames, handles F0 (break) and E0 (extended) prefixes,
//   and translates supported keys to USB HID usage codes.
// - Maintains up to two simultaneously held keys so diagonal/overlapping presses survive.

---
 rtl/ps2_pkg.sv | 45 ++++
 rtl/ps2_keycode_rx_if.sv | 10 +
 rtl/ps2_line_filter.sv | 50 +++++
 rtl/ps2_keycode_rx.sv | 135 +++++++++++++
 tb/tb_ps2_keycode_rx.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keycode receiver.
// Covers the frame states, scan-code-set-2 and HID byte values, and the set-2 to HID map.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam logic [7:0] PREFIX_EXT = 8'hE0;

    localparam logic [7:0] SET2_W     = 8'h1D;
    localparam logic [7:0] SET2_A     = 8'h1C;
    localparam logic [7:0] SET2_S     = 8'h1B;
    localparam logic [7:0] SET2_D     = 8'h23;
    localparam logic [7:0] SET2_SPACE = 8'h29;
    localparam logic [7:0] SET2_ENTER = 8'h5A;
    localparam logic [7:0] SET2_ESC   = 8'h76;

    localparam logic [7:0] HID_NONE   = 8'h00;
    localparam logic [7:0] HID_W      = 8'h1A;
    localparam logic [7:0] HID_A      = 8'h04;
    localparam logic [7:0] HID_S      = 8'h16;
    localparam logic [7:0] HID_D      = 8'h07;
    localparam logic [7:0] HID_SPACE  = 8'h2C;
    localparam logic [7:0] HID_ENTER  = 8'h28;
    localparam logic [7:0] HID_ESC    = 8'h29;

    localparam int NUM_SLOTS = 2;

    // Unsupported scan codes map to HID_NONE, which the slot logic treats as "ignore".
    function automatic logic [7:0] set2_to_hid(input logic [7:0] sc);
        logic [7:0] hid;
        case (sc)
            SET2_W:     hid = HID_W;
            SET2_A:     hid = HID_A;
            SET2_S:     hid = HID_S;
            SET2_D:     hid = HID_D;
            SET2_SPACE: hid = HID_SPACE;
            SET2_ENTER: hid = HID_ENTER;
            SET2_ESC:   hid = HID_ESC;
            default:    hid = HID_NONE;
        endcase
        return hid;
    endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Keycode bus from the PS/2 receiver to the game logic.
// keycode[7:0] is slot0, keycode[15:8] is slot1; 8'h00 marks an empty slot.
interface ps2_keycode_rx_if;
    logic [15:0] keycode;
    logic        key_event;
    logic        frame_err;

    modport master (output keycode, output key_event, output frame_err);
    modport slave  (input  keycode, input  key_event, input  frame_err);
endinterface

// File: rtl/ps2_line_filter.sv
// Conditions the raw PS/2 lines: 2-FF synchronisers, a glitch filter on the
// clock line, and a one-cycle strobe on each filtered falling edge.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic fall,
    output logic dat
);

    localparam int CW = $clog2(FILTER_LEN) + 1;

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic [CW-1:0] run_cnt;

    // Synchronise both lines; the filtered clock only follows after FILTER_LEN
    // consecutive samples that disagree with it, and a 1->0 move raises fall.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            run_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            fall     <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                run_cnt  <= '0;
                fall     <= clk_filt;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

    // Data settles long before the keyboard drops its clock, so the synced
    // value is stable when the delayed fall strobe arrives.
    assign dat = dat_sync[1];

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: frames scan-code-set-2 bytes, tracks F0/E0 prefixes,
// translates supported keys to HID usages and holds up to two pressed keys.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             PS2_CLK,
    input  logic             PS2_DAT,
    ps2_keycode_rx_if.master kc_bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic                           fall;
    logic                           dat;
    rx_state_t                      state;
    logic [2:0]                     bit_cnt;
    logic [7:0]                     shreg;
    logic                           parity_ok;
    logic [TW-1:0]                  tmo;
    logic                           brk;
    logic                           ext;
    logic [NUM_SLOTS-1:0][7:0]      slots;
    logic [NUM_SLOTS-1:0][7:0]      slot_nxt;
    logic                           key_event;
    logic                           frame_err;
    logic                           byte_ok;
    logic [7:0]                     hid;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .Clk     (Clk),
        .Reset   (Reset),
        .ps2_clk (PS2_CLK),
        .ps2_dat (PS2_DAT),
        .fall    (fall),
        .dat     (dat)
    );

    // Byte acceptance and the resulting slot contents, consumed on the stop-bit fall.
    always_comb begin
        byte_ok  = (state == STOP) && dat && parity_ok;
        hid      = set2_to_hid(shreg);
        slot_nxt = slots;
        if (byte_ok && shreg != PREFIX_BRK && shreg != PREFIX_EXT && !ext && hid != HID_NONE) begin
            if (brk) begin
                // Release clears every matching slot in place; no compaction.
                for (int i = 0; i < NUM_SLOTS; i++)
                    if (slots[i] == hid) slot_nxt[i] = HID_NONE;
            end else if (slots[0] == hid || slots[1] == hid) begin
                // Typematic repeat of a held key: leave slots alone.
                slot_nxt = slots;
            end else if (slots[0] == HID_NONE) begin
                slot_nxt[0] = hid;
            end else begin
                // Slot1 takes the newest key whether empty or not.
                slot_nxt[1] = hid;
            end
        end
    end

    // Frame FSM, timeout watchdog, prefix flags and slot registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            parity_ok <= 1'b0;
            tmo       <= '0;
            brk       <= 1'b0;
            ext       <= 1'b0;
            slots     <= '0;
            key_event <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            key_event <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE || fall) tmo <= '0;
            else                       tmo <= tmo + 1'b1;

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {dat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity_ok <= ^{dat, shreg};
                        state     <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (byte_ok) begin
                            if (shreg == PREFIX_BRK) begin
                                brk <= 1'b1;
                            end else if (shreg == PREFIX_EXT) begin
                                ext <= 1'b1;
                            end else begin
                                brk <= 1'b0;
                                ext <= 1'b0;
                            end
                            slots     <= slot_nxt;
                            key_event <= (slot_nxt != slots);
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE && tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                // Keyboard stalled mid-frame: drop the partial byte and any prefix.
                state     <= IDLE;
                bit_cnt   <= '0;
                brk       <= 1'b0;
                ext       <= 1'b0;
                frame_err <= 1'b1;
            end
        end
    end

    assign kc_bus.keycode   = slots;
    assign kc_bus.key_event = key_event;
    assign kc_bus.frame_err = frame_err;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: drives PS/2 frames bit by bit and checks
// the keycode bus against hand-computed values.
module tb_ps2_keycode_rx;

    localparam int TMO = 2000;

    logic Clk     = 1'b0;
    logic Reset   = 1'b1;
    logic PS2_CLK = 1'b1;
    logic PS2_DAT = 1'b1;

    ps2_keycode_rx_if kc_bus ();

    ps2_keycode_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .kc_bus  (kc_bus)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;
    int ev_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int silent_chg = 0;
    logic in_rst = 1'b1;
    logic [15:0] kc_prev = '0;

    // Event monitor: counts pulses and flags keycode changes without key_event.
    always @(negedge Clk) begin
        if (kc_bus.key_event) ev_cnt <= ev_cnt + 1;
        if (kc_bus.frame_err) fe_cnt <= fe_cnt + 1;
        if (kc_bus.key_event && kc_bus.frame_err) both_cnt <= both_cnt + 1;
        if (!in_rst && kc_bus.keycode != kc_prev && !kc_bus.key_event) silent_chg <= silent_chg + 1;
        kc_prev <= kc_bus.keycode;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DAT = b;
        cyc(10);
        PS2_CLK = 1'b0;
        cyc(20);
        PS2_CLK = 1'b1;
        cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(stop_b);
        PS2_DAT = 1'b1;
        cyc(20);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b0, 1'b1);
    endtask

    int ev_mark;

    initial begin
        cyc(5);
        Reset = 1'b0;
        cyc(2);
        in_rst = 1'b0;

        // Idle lines after reset
        cyc(1000);
        chk("idle_keycode", 32'(kc_bus.keycode), 32'h0000);
        chk("idle_events", ev_cnt, 0);
        chk("idle_errors", fe_cnt, 0);

        // Single make and its break
        send_byte(8'h1D);
        chk("make_w", 32'(kc_bus.keycode), 32'h001A);
        chk("make_w_event", ev_cnt, 1);
        send_byte(8'hF0);
        chk("brk_prefix_nochg", 32'(kc_bus.keycode), 32'h001A);
        send_byte(8'h1D);
        chk("break_w", 32'(kc_bus.keycode), 32'h0000);
        chk("break_w_event", ev_cnt, 2);

        // Two slots, then overwrite slot1, then release slot0
        send_byte(8'h1C);
        send_byte(8'h23);
        chk("two_keys", 32'(kc_bus.keycode), 32'h0704);
        send_byte(8'h1B);
        chk("slot1_overwrite", 32'(kc_bus.keycode), 32'h1604);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("break_slot0", 32'(kc_bus.keycode), 32'h1600);
        send_byte(8'hF0);
        send_byte(8'h1B);
        chk("break_slot1", 32'(kc_bus.keycode), 32'h0000);

        // Typematic repeat and extended-key suppression
        send_byte(8'h1D);
        ev_mark = ev_cnt;
        send_byte(8'h1D);
        chk("repeat_no_event", ev_cnt, ev_mark);
        send_byte(8'hE0);
        send_byte(8'h75);
        chk("ext_ignored", 32'(kc_bus.keycode), 32'h001A);
        chk("ext_no_event", ev_cnt, ev_mark);
        send_byte(8'h1C);
        chk("after_ext_slot1", 32'(kc_bus.keycode), 32'h041A);

        // Framing errors
        send_frame(8'h1D, 1'b1, 1'b1);
        chk("parity_err", fe_cnt, 1);
        chk("parity_keep", 32'(kc_bus.keycode), 32'h041A);
        send_frame(8'h1D, 1'b0, 1'b0);
        chk("stop_err", fe_cnt, 2);
        ps2_bit(1'b1);
        cyc(20);
        chk("bad_start_silent", fe_cnt, 2);

        // Stalled frame times out, next frame is clean
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        cyc(TMO / 2);
        chk("timeout_not_early", fe_cnt, 2);
        cyc(TMO / 2 + 100);
        chk("timeout_err", fe_cnt, 3);
        send_byte(8'h23);
        chk("after_timeout", 32'(kc_bus.keycode), 32'h071A);
        chk("error_count_final", fe_cnt, 3);

        // Reset in the middle of a frame
        in_rst = 1'b1;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        Reset = 1'b1;
        cyc(1);
        chk("rst_keycode", 32'(kc_bus.keycode), 32'h0000);
        chk("rst_event", 32'(kc_bus.key_event), 32'h0);
        chk("rst_err", 32'(kc_bus.frame_err), 32'h0);
        Reset = 1'b0;
        PS2_DAT = 1'b1;
        cyc(20);
        in_rst = 1'b0;
        send_byte(8'h1C);
        chk("post_rst_frame", 32'(kc_bus.keycode), 32'h0004);

        chk("event_err_overlap", both_cnt, 0);
        chk("silent_keycode_chg", silent_chg, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
